// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, flit type codes, head-flit field offsets
// and the injector FSM encoding.
package noc_pkg;

  localparam int FW = 40;
  localparam int CW = 3;
  localparam int LW = 8;

  typedef enum logic [1:0] {
    FT_INV  = 2'b00,
    FT_TAIL = 2'b01,
    FT_BODY = 2'b10,
    FT_HEAD = 2'b11
  } flit_type_e;

  // Head flit, MSB first: type | dst x,y,z | src x,y,z | len | zero pad
  localparam int HEAD_TYPE_LSB = FW - 2;
  localparam int HEAD_DST_LSB  = HEAD_TYPE_LSB - 3*CW;
  localparam int HEAD_SRC_LSB  = HEAD_DST_LSB - 3*CW;
  localparam int HEAD_LEN_LSB  = HEAD_SRC_LSB - LW;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/ni_packetizer.sv
// Network-interface injector: turns a descriptor plus payload stream into one
// wormhole packet (head, LEN payload flits, last typed tail) behind a single output register.
module ni_packetizer #(
  parameter int FW   = noc_pkg::FW,
  parameter int CW   = noc_pkg::CW,
  parameter int LW   = noc_pkg::LW,
  parameter int MY_X = 0,
  parameter int MY_Y = 0,
  parameter int MY_Z = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            msg_valid,
  output logic            msg_ready,
  input  logic [3*CW-1:0] msg_dst,
  input  logic [LW-1:0]   msg_len,
  input  logic            pl_valid,
  output logic            pl_ready,
  input  logic [FW-3:0]   pl_data,
  input  logic            pl_last,
  output logic [FW-1:0]   flit_out,
  output logic            req_out,
  input  logic            grnt_in,
  output logic            len_err,
  output logic [15:0]     pkt_cnt
);
  import noc_pkg::*;

  localparam int PADW = FW - 2 - 6*CW - LW;

  state_e       state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [FW-1:0] flit_d, head_flit;
  logic          req_d, err_d, slot, xfer;
  logic [15:0]   cnt_d;
  flit_type_e    pl_type;

  assign head_flit = {FT_HEAD, msg_dst, CW'(MY_X), CW'(MY_Y), CW'(MY_Z), msg_len, {PADW{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    flit_d    = flit_out;
    req_d     = req_out;
    rem_d     = rem_q;
    cnt_d     = pkt_cnt;
    err_d     = 1'b0;
    msg_ready = 1'b0;
    pl_ready  = 1'b0;
    pl_type   = (rem_q == LW'(1)) ? FT_TAIL : FT_BODY;
    // slot: the register is empty or is being emptied on this edge
    slot      = ~req_out | grnt_in;
    xfer      = req_out & grnt_in;
    if (xfer) req_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          flit_d  = head_flit;
          req_d   = 1'b1;
          rem_d   = msg_len;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (rem_q != '0) begin
          pl_ready = slot;
          if (slot && pl_valid) begin
            flit_d = {pl_type, pl_data};
            req_d  = 1'b1;
            rem_d  = rem_q - LW'(1);
            // pl_last is only cross-checked; the length counter decides the tail
            err_d  = pl_last ? (rem_q > LW'(1)) : (rem_q == LW'(1));
            if (rem_q == LW'(1)) state_d = ST_DRAIN;
          end
        end else if (slot) begin
          flit_d  = {FT_TAIL, {(FW-2){1'b0}}};
          req_d   = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (xfer) begin
          cnt_d   = pkt_cnt + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_out <= '0;
      req_out  <= 1'b0;
      rem_q    <= '0;
      len_err  <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      flit_out <= flit_d;
      req_out  <= req_d;
      rem_q    <= rem_d;
      len_err  <= err_d;
      pkt_cnt  <= cnt_d;
    end
  end

endmodule
